// File: rtl/control_unit_pkg.sv
// Shared CPU encodings and the control-strobe bundle used by the main decoder.
// Holds opcode/ALUOp constants plus the NOP value and a legality check.
package cpu_defs;

  typedef logic [1:0] opcode_t;

  localparam opcode_t OP_ADD = 2'b00;
  localparam opcode_t OP_LW  = 2'b01;
  localparam opcode_t OP_SW  = 2'b10;
  localparam opcode_t OP_J   = 2'b11;

  localparam logic ALUOP_ADD   = 1'b0;
  localparam logic ALUOP_FUNCT = 1'b1;

  // Field order matches the outputs as they are listed on control_unit.
  typedef struct packed {
    logic reg_dst;
    logic reg_write;
    logic alu_src;
    logic branch;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // True when a strobe set respects the datapath exclusion rules.
  function automatic logic ctrl_legal(input ctrl_t c);
    logic ok;
    ok = 1'b1;
    if (c.mem_read && c.mem_write)                ok = 1'b0;
    if (c.branch && (c.reg_write || c.mem_write)) ok = 1'b0;
    if (c.mem_to_reg && !c.mem_read)              ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational opcode-to-strobe decoder for the 8-bit CPU.
// Only instruction bits [7:6] reach this block.
module control_decode
  import cpu_defs::*;
(
  input  opcode_t opcode_i,
  output ctrl_t   ctrl_o
);

  always_comb begin
    ctrl_o = CTRL_NOP;
    case (opcode_i)
      OP_ADD: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      OP_LW: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.alu_op     = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      OP_J: begin
        ctrl_o.branch = 1'b1;
      end
      default: ctrl_o = CTRL_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Main control unit: decodes the opcode and registers the strobes (1-cycle latency).
// Synchronous reset inserts a NOP bubble on the outputs.
module control_unit
  import cpu_defs::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Instruction,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUsrc,
  output logic       Branch,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       ALUOp
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  control_decode u_decode (
    .opcode_i (Instruction),
    .ctrl_o   (ctrl_d)
  );

  always_ff @(posedge clk) begin
    if (reset) ctrl_q <= CTRL_NOP;
    else       ctrl_q <= ctrl_d;
  end

  assign RegDst   = ctrl_q.reg_dst;
  assign RegWrite = ctrl_q.reg_write;
  assign ALUsrc   = ctrl_q.alu_src;
  assign Branch   = ctrl_q.branch;
  assign MemRead  = ctrl_q.mem_read;
  assign MemWrite = ctrl_q.mem_write;
  assign MemtoReg = ctrl_q.mem_to_reg;
  assign ALUOp    = ctrl_q.alu_op;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed vector table, full-byte sweep
// with a mid-sweep reset, and per-cycle invariant checks via a scoreboard queue.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] instr;
  logic       RegDst, RegWrite, ALUsrc, Branch, MemRead, MemWrite, MemtoReg, ALUOp;
  logic [7:0] dut_vec;

  int tests  = 0;
  int errors = 0;

  logic [7:0] sb_q[$];

  always #50 clk = ~clk;

  control_unit dut (
    .clk         (clk),
    .reset       (reset),
    .Instruction (instr[7:6]),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUsrc      (ALUsrc),
    .Branch      (Branch),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .ALUOp       (ALUOp)
  );

  assign dut_vec = {RegDst, RegWrite, ALUsrc, Branch, MemRead, MemWrite, MemtoReg, ALUOp};

  // {RegDst RegWrite ALUsrc Branch MemRead MemWrite MemtoReg ALUOp}
  function automatic logic [7:0] model(input logic rst, input logic [1:0] op);
    if (rst) return 8'b0000_0000;
    case (op)
      2'b00:   return 8'b1100_0001;
      2'b01:   return 8'b0110_1010;
      2'b10:   return 8'b0010_0100;
      default: return 8'b0001_0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_inv(input string name);
    logic ok;
    ok = !(MemRead && MemWrite) && !(Branch && (RegWrite || MemWrite)) && !(MemtoReg && !MemRead);
    tests++;
    if (!ok) begin
      errors++;
      $display("FAIL %s invariant: got %b expected legal strobe set", name, dut_vec);
    end
  endtask

  // Drive one cycle; the expectation is queued at drive time and retired after the edge.
  task automatic step(input string name, input logic rst, input logic [7:0] ins,
                      input logic [7:0] exp);
    logic [7:0] e;
    reset = rst;
    instr = ins;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      tests++;
      errors++;
      $display("FAIL %s: got empty scoreboard expected one entry", name);
    end else begin
      e = sb_q.pop_front();
      check(name, dut_vec, e);
    end
    check_inv(name);
  endtask

  typedef struct {
    string      name;
    logic       rst;
    logic [7:0] ins;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[$];

  initial begin
    reset = 1'b1;
    instr = 8'hC0;

    vt.push_back('{"reset0",    1'b1, 8'hC0, 8'b0000_0000});
    vt.push_back('{"reset1",    1'b1, 8'hFF, 8'b0000_0000});
    vt.push_back('{"add",       1'b0, 8'h00, 8'b1100_0001});
    vt.push_back('{"lw",        1'b0, 8'h55, 8'b0110_1010});
    vt.push_back('{"sw",        1'b0, 8'hA3, 8'b0010_0100});
    vt.push_back('{"j",         1'b0, 8'hC7, 8'b0001_0000});
    vt.push_back('{"add_lowx",  1'b0, 8'h3F, 8'b1100_0001});
    vt.push_back('{"rst_mid",   1'b1, 8'h40, 8'b0000_0000});
    vt.push_back('{"lw_after",  1'b0, 8'h40, 8'b0110_1010});
    vt.push_back('{"j_b2b",     1'b0, 8'hC0, 8'b0001_0000});
    vt.push_back('{"sw_b2b",    1'b0, 8'h80, 8'b0010_0100});

    foreach (vt[i]) step(vt[i].name, vt[i].rst, vt[i].ins, vt[i].exp);

    // Full-byte sweep wrapping twice; reset pulses over two LW opcodes mid-sweep.
    for (int i = 0; i < 512; i++) begin
      logic [7:0] b;
      logic       r;
      b = i[7:0];
      r = (i == 320) || (i == 321);
      step(r ? "sweep_rst" : "sweep", r, b, model(r, b[7:6]));
    end

    // LW must reappear on the very first edge after reset drops.
    step("rst_hold", 1'b1, 8'h7E, 8'b0000_0000);
    step("lw_first", 1'b0, 8'h7E, 8'b0110_1010);

    tests++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
